// File: rtl/agc_lock_monitor.sv
// AGC output level monitor: per-window average of max(|re|,|im|), lock FSM,
// and the gain_en control that can freeze AGC adaptation once locked.
//
// state   | meaning
// --------+---------------------------------------------------------------
// ACQUIRE | counting consecutive good windows toward lock
// LOCKED  | loop settled; counting consecutive bad windows toward unlock
// SETTLE  | lock just lost; next window is discarded while gain re-adapts
module agc_lock_monitor #(
    parameter int SAMPLE_WH  = 16,
    parameter int SAMPLE_FR  = 15,
    parameter int WIN_LOG2   = 6,
    parameter int TARGET     = 8192,
    parameter int TOL        = 1024,
    parameter int LOCK_CNT   = 4,
    parameter int UNLOCK_CNT = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    input  logic [SAMPLE_WH-1:0] in_real,
    input  logic [SAMPLE_WH-1:0] in_imag,
    input  logic                 freeze_en,
    output logic                 gain_en,
    output logic                 locked,
    output logic [SAMPLE_WH-1:0] level,
    output logic                 level_valid,
    output logic                 lost
);

    localparam int MAG_W = SAMPLE_WH - 1;
    localparam int ACC_W = SAMPLE_WH - 1 + WIN_LOG2;
    localparam int DW    = SAMPLE_WH + 2;
    localparam int GC_W  = $clog2(LOCK_CNT + 1);
    localparam int BC_W  = $clog2(UNLOCK_CNT + 1);

    if (SAMPLE_FR >= SAMPLE_WH || LOCK_CNT < 1 || UNLOCK_CNT < 1) begin : g_param_check
        $error("agc_lock_monitor: illegal parameter set");
    end

    typedef enum logic [1:0] {ACQUIRE, LOCKED, SETTLE} state_t;

    state_t               state_q, state_d;
    logic [MAG_W-1:0]     mag_q, mag_d;
    logic                 mag_v_q, mag_v_d;
    logic [ACC_W-1:0]     acc_q, acc_d;
    logic [WIN_LOG2-1:0]  cnt_q, cnt_d;
    logic [SAMPLE_WH-1:0] level_q, level_d;
    logic                 level_valid_q, level_valid_d;
    logic                 lost_q, lost_d;
    logic                 locked_q, locked_d;
    logic [GC_W-1:0]      good_cnt_q, good_cnt_d, good_inc;
    logic [BC_W-1:0]      bad_cnt_q, bad_cnt_d, bad_inc;

    logic [ACC_W-1:0]     sum;
    logic [MAG_W-1:0]     avg, abs_re, abs_im;
    logic                 win_done, win_good;
    logic signed [DW-1:0] diff;

    // Most negative code has no positive twin; clamp it to full scale.
    function automatic logic [MAG_W-1:0] sat_abs(input logic [SAMPLE_WH-1:0] x);
        logic [MAG_W-1:0] neg;
        neg = ~x[MAG_W-1:0] + 1'b1;
        if (!x[SAMPLE_WH-1]) return x[MAG_W-1:0];
        if (x[MAG_W-1:0] == '0) return '1;
        return neg;
    endfunction

    always_comb begin
        abs_re   = sat_abs(in_real);
        abs_im   = sat_abs(in_imag);
        mag_d    = in_valid ? ((abs_re > abs_im) ? abs_re : abs_im) : mag_q;
        mag_v_d  = in_valid;

        sum      = acc_q + ACC_W'(mag_q);
        avg      = sum[ACC_W-1:WIN_LOG2];
        win_done = mag_v_q && (cnt_q == '1);
        diff     = $signed(DW'(avg)) - $signed(DW'(TARGET));
        win_good = (diff <= $signed(DW'(TOL))) && (diff >= -$signed(DW'(TOL)));

        acc_d         = acc_q;
        cnt_d         = cnt_q;
        level_d       = level_q;
        level_valid_d = 1'b0;
        if (mag_v_q) begin
            cnt_d = cnt_q + 1'b1;
            acc_d = win_done ? '0 : sum;
        end
        if (win_done) begin
            level_d       = SAMPLE_WH'(avg);
            level_valid_d = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        bad_cnt_d  = bad_cnt_q;
        lost_d     = 1'b0;
        good_inc   = good_cnt_q + 1'b1;
        bad_inc    = bad_cnt_q + 1'b1;
        if (win_done) begin
            case (state_q)
                ACQUIRE: begin
                    if (!win_good) begin
                        good_cnt_d = '0;
                    end else if (good_inc == GC_W'(LOCK_CNT)) begin
                        state_d    = LOCKED;
                        good_cnt_d = '0;
                        bad_cnt_d  = '0;
                    end else begin
                        good_cnt_d = good_inc;
                    end
                end
                LOCKED: begin
                    if (win_good) begin
                        bad_cnt_d = '0;
                    end else if (bad_inc == BC_W'(UNLOCK_CNT)) begin
                        state_d    = SETTLE;
                        lost_d     = 1'b1;
                        good_cnt_d = '0;
                        bad_cnt_d  = '0;
                    end else begin
                        bad_cnt_d = bad_inc;
                    end
                end
                SETTLE:  state_d = ACQUIRE;
                default: state_d = ACQUIRE;
            endcase
        end
        locked_d = (state_d == LOCKED);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ACQUIRE;
            mag_q         <= '0;
            mag_v_q       <= 1'b0;
            acc_q         <= '0;
            cnt_q         <= '0;
            level_q       <= '0;
            level_valid_q <= 1'b0;
            lost_q        <= 1'b0;
            locked_q      <= 1'b0;
            good_cnt_q    <= '0;
            bad_cnt_q     <= '0;
        end else begin
            state_q       <= state_d;
            mag_q         <= mag_d;
            mag_v_q       <= mag_v_d;
            acc_q         <= acc_d;
            cnt_q         <= cnt_d;
            level_q       <= level_d;
            level_valid_q <= level_valid_d;
            lost_q        <= lost_d;
            locked_q      <= locked_d;
            good_cnt_q    <= good_cnt_d;
            bad_cnt_q     <= bad_cnt_d;
        end
    end

    assign level       = level_q;
    assign level_valid = level_valid_q;
    assign lost        = lost_q;
    assign locked      = locked_q;
    assign gain_en     = ~(locked_q & freeze_en);

endmodule

// File: tb/tb_agc_lock_monitor.sv
// Scoreboard bench for agc_lock_monitor: a window-level reference model pushes
// expected {level, locked, lost} per window; a monitor pops on level_valid.
module tb_agc_lock_monitor;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic [15:0] in_real;
    logic [15:0] in_imag;
    logic        freeze_en;
    logic        gain_en;
    logic        locked;
    logic [15:0] level;
    logic        level_valid;
    logic        lost;

    agc_lock_monitor dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_real     (in_real),
        .in_imag     (in_imag),
        .freeze_en   (freeze_en),
        .gain_en     (gain_en),
        .locked      (locked),
        .level       (level),
        .level_valid (level_valid),
        .lost        (lost)
    );

    always #5 clk = ~clk;

    typedef struct {
        int lvl;
        bit lck;
        bit lst;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;
    int   windows_seen = 0;
    bit   cur_locked = 1'b0;

    // reference model: window sum, and lock rules in window units
    int m_sum, m_n, m_good_run, m_bad_run, m_settle_skip;
    bit m_locked;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic int mag_of(input int re, input int im);
        int ar, ai;
        ar = (re < 0) ? -re : re;
        ai = (im < 0) ? -im : im;
        if (ar > 32767) ar = 32767;
        if (ai > 32767) ai = 32767;
        return (ar > ai) ? ar : ai;
    endfunction

    task automatic model_reset();
        m_sum = 0; m_n = 0; m_good_run = 0; m_bad_run = 0;
        m_settle_skip = 0; m_locked = 1'b0;
        q.delete();
    endtask

    task automatic model_sample(input int re, input int im);
        int  avg;
        bit  good, lst;
        m_sum += mag_of(re, im);
        m_n++;
        if (m_n == 64) begin
            avg  = m_sum / 64;
            m_sum = 0;
            m_n  = 0;
            good = (avg >= 8192 - 1024) && (avg <= 8192 + 1024);
            lst  = 1'b0;
            if (m_settle_skip != 0) begin
                m_settle_skip = 0;
            end else if (!m_locked) begin
                m_good_run = good ? m_good_run + 1 : 0;
                if (m_good_run == 4) begin
                    m_locked = 1'b1; m_good_run = 0; m_bad_run = 0;
                end
            end else begin
                m_bad_run = good ? 0 : m_bad_run + 1;
                if (m_bad_run == 2) begin
                    m_locked = 1'b0; lst = 1'b1; m_settle_skip = 1;
                    m_good_run = 0; m_bad_run = 0;
                end
            end
            q.push_back('{avg, m_locked, lst});
        end
    endtask

    // one valid sample followed by `gap` idle cycles
    task automatic send(input int re, input int im, input int gap);
        @(posedge clk); #1;
        in_valid = 1'b1;
        in_real  = re[15:0];
        in_imag  = im[15:0];
        model_sample(re, im);
        for (int g = 0; g < gap; g++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
            in_real  = 16'($urandom);
            in_imag  = 16'($urandom);
        end
    endtask

    task automatic send_window(input int re, input int im, input int gap);
        for (int i = 0; i < 64; i++) send(re, im, gap);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk); #1;
            in_valid = 1'b0;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_level"},       int'(level), 0);
        check({tag, "_level_valid"}, int'(level_valid), 0);
        check({tag, "_lost"},        int'(lost), 0);
        check({tag, "_locked"},      int'(locked), 0);
        check({tag, "_gain_en"},     int'(gain_en), 1);
    endtask

    // monitor
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst) begin
                cur_locked = 1'b0;
            end else begin
                if (level_valid) begin
                    windows_seen++;
                    if (q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL unexpected_level_valid actual=1 expected=0 t=%0t", $time);
                    end else begin
                        e = q.pop_front();
                        check("level", int'(level), e.lvl);
                        check("locked_at_window", int'(locked), int'(e.lck));
                        check("lost_at_window", int'(lost), int'(e.lst));
                        cur_locked = e.lck;
                    end
                end else begin
                    check("lost_idle", int'(lost), 0);
                end
                check("locked_hold", int'(locked), int'(cur_locked));
                check("gain_en", int'(gain_en), int'(!(cur_locked && freeze_en)));
            end
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int base, re, im, gap;
        rst = 1'b1; in_valid = 1'b0; in_real = '0; in_imag = '0; freeze_en = 1'b1;
        model_reset();
        #1;
        check_reset_outputs("por");
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // lock on exact target, then stay locked
        for (int w = 0; w < 5; w++) send_window(8192, 0, 0);
        // drop level: lose lock on 2nd bad window, skip one, relock after 4 good
        for (int w = 0; w < 3; w++) send_window(2000, 0, 0);
        for (int w = 0; w < 4; w++) send_window(8192, 0, 0);
        idle(3);
        check("relocked", int'(locked), 1);

        // async reset 30 samples into a window, while locked
        for (int i = 0; i < 30; i++) send(8192, 0, 0);
        #2;
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        check_reset_outputs("midwin");
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // full-scale negative input saturates, never locks
        for (int w = 0; w < 3; w++) send_window(-32768, -100, 0);
        // alternating edge-of-tolerance windows, then a clean run locks
        for (int w = 0; w < 6; w++) send_window((w % 2) ? 9217 : -9216, 3000, 0);
        for (int w = 0; w < 4; w++) send_window(0, 9216, 0);
        // sparse valids
        for (int w = 0; w < 2; w++) send_window(8192, 0, 2);

        // randomized windows with gaps and freeze_en toggling
        for (int w = 0; w < 16; w++) begin
            base = $urandom_range(6800, 9600);
            freeze_en = 1'($urandom);
            for (int i = 0; i < 64; i++) begin
                re  = base - $urandom_range(0, 400);
                im  = $urandom_range(0, base);
                if ($urandom_range(0, 1)) re = -re;
                if ($urandom_range(0, 1)) im = -im;
                if ($urandom_range(0, 63) == 0) re = -32768;
                gap = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0;
                send(re, im, gap);
            end
        end

        idle(2);
        for (int i = 0; i < 20 && q.size() != 0; i++) idle(1);
        check("queue_drained", q.size(), 0);
        check("windows_seen", windows_seen, 43);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
